uart_cmd_parser: RTL
====================

Name: uart_cmd_parser

Overview:
- Frame-level receive controller behind my_uart_rx.
- Consumes one-cycle rx_rdy/rx_data byte strobes from the UART receiver and assembles them into host command frames of the form HDR, CMD, LEN, LEN payload bytes, CHK.
- Buffers the payload, verifies the checksum and presents a validated command to the workstation control logic with a valid/ack handshake.
- Flags framing, length, checksum, overrun and (optionally) timeout errors.

Parameters:
- MAX_LEN, 16: maximum payload bytes per frame.
- AW, 4: payload buffer address width; 2**AW >= MAX_LEN.
- HDR, 8'hAA: frame header byte.
- TIMEOUT_CYCLES, 21700: inter-byte timeout in clk cycles (about 10 byte times at 115200 baud on a 25 MHz clk).

Ports:
- clk  in  1  system clock, 25 MHz.
- rst  in  1  asynchronous active-low reset.
- rx_data  in  8  received byte; valid when rx_rdy=1.
- rx_rdy  in  1  one-cycle byte-received strobe.
- cmd_valid  out  1  validated command pending; held until cmd_ack.
- cmd_ack  in  1  consumer accepts the command.
- cmd_code  out  8  CMD byte of the pending frame.
- cmd_len  out  AW+1  payload length of the pending frame.
- pl_raddr  in  AW  payload read address.
- pl_rdata  out  8  payload byte at pl_raddr; registered, 1-cycle latency.
- chk_err  out  1  one-cycle pulse: checksum mismatch.
- len_err  out  1  one-cycle pulse: LEN > MAX_LEN.
- ovf_err  out  1  one-cycle pulse: byte dropped while a command is pending.
- tmo_err  out  1  one-cycle pulse: inter-byte timeout; tied 0 without UART_CMD_TIMEOUT_EN.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst=0):
  - State to IDLE.
  - All outputs to 0: cmd_valid, cmd_code, cmd_len, pl_rdata, all err pulses, busy.
  - Byte counter and running checksum to 0.
  - Buffer contents undefined.
  - Reset mid-frame discards the partial frame.
- States: IDLE, CMD, LEN, DATA, CHK, HOLD.
- Bytes are only consumed on rx_rdy=1 cycles. All transitions below occur on such a cycle unless stated otherwise.
- IDLE:
  - rx_data==HDR goes to CMD.
  - Any other byte is silently discarded and the state stays IDLE.
- CMD:
  - Latch the byte as the shadow command code.
  - Checksum := byte.
  - Go to LEN.
- LEN:
  - If byte > MAX_LEN: pulse len_err and go to IDLE.
  - Otherwise latch the shadow length, add the byte to the checksum and clear the byte counter.
  - Go to DATA if byte != 0, or to CHK if byte == 0.
- DATA:
  - Write byte to buffer[cnt] and add it to the checksum.
  - cnt increments.
  - When cnt reaches len-1 on this write, go to CHK.
- CHK, byte == checksum[7:0]:
  - Checksum is the 8-bit modulo-256 sum of CMD, LEN and all payload bytes.
  - Next cycle: cmd_code := shadow code, cmd_len := shadow length, cmd_valid := 1.
  - Go to HOLD.
- CHK, mismatch: pulse chk_err and go to IDLE.
- HOLD:
  - cmd_valid stays high; cmd_code, cmd_len and the buffer are stable.
  - Buffer writes occur only in DATA, so the payload cannot change while a command is pending.
  - cmd_ack=1 clears cmd_valid the next cycle and moves to IDLE.
  - rx_rdy without cmd_ack: byte dropped, ovf_err pulses.
  - rx_rdy and cmd_ack in the same cycle: ack wins; the byte is evaluated as an IDLE byte (HDR goes straight to CMD), no ovf_err.
- cmd_ack outside HOLD is ignored.
- Error pulses are registered: asserted on the cycle after the offending rx_rdy, width exactly 1.
- pl_rdata <= buffer[pl_raddr] every cycle. Reads are valid whenever cmd_valid=1. Addresses >= cmd_len return don't-care.

Optional Feature:
- Macro: UART_CMD_TIMEOUT_EN.
- Defined:
  - A counter of width ceil(log2(TIMEOUT_CYCLES+1)) clears on every rx_rdy.
  - It counts up while in CMD, LEN, DATA or CHK.
  - On reaching TIMEOUT_CYCLES: pulse tmo_err, go to IDLE and discard the partial frame.
  - The counter is held at 0 in IDLE and HOLD.
- Not defined: no counter logic; tmo_err is tied 0; a stalled frame waits indefinitely.

Decomposition:
- Package uart_cmd_pkg:
  - State encoding constants.
  - Default header byte, 8'hAA.
  - Checksum width.
- Sub-module uart_cmd_buf: MAX_LEN x 8 single-write, registered-read buffer. Write enable/address from the parser, read address from pl_raddr.

Test Plan:
- Bytes AA 10 02 55 66 CD, then cmd_ack after 5 cycles -> cmd_valid=1 with cmd_code=8'h10, cmd_len=2, buf[0]=55, buf[1]=66; cmd_valid falls the cycle after ack.
- Bytes AA 10 02 55 66 CE -> one chk_err pulse, cmd_valid stays 0, busy returns 0.
- Bytes AA 20 11 (LEN 17 > 16) -> len_err pulse, state IDLE; following AA 20 00 20 -> cmd_valid with cmd_len=0.
- While cmd_valid is held, send 33 -> ovf_err pulse, payload unchanged. Then AA coincident with cmd_ack, followed by 05 00 05 -> second command accepted with cmd_code=8'h05.
- With UART_CMD_TIMEOUT_EN: AA 10, then idle for 21700 cycles -> tmo_err pulse, IDLE. Without the macro, the same stimulus stays in LEN and tmo_err stays 0.
- Assert rst mid-DATA (after AA 10 04 01) -> all outputs 0; a subsequent full frame parses correctly.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command-frame parser.
package uart_cmd_pkg;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_CMD  = 3'd1,
      S_LEN  = 3'd2,
      S_DATA = 3'd3,
      S_CHK  = 3'd4,
      S_HOLD = 3'd5
   } state_t;

   localparam logic [7:0] HDR_DEFAULT = 8'hAA;
   localparam int         CHK_W       = 8;

endpackage

// File: rtl/uart_cmd_buf.sv
// Payload buffer: single write port from the parser, registered read port for the consumer.
module uart_cmd_buf #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [7:0]    wdata,
   input  logic [AW-1:0] raddr,
   output logic [7:0]    rdata
);

   localparam logic [AW:0] DEPTH_A = (AW+1)'(DEPTH);

   logic [7:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // Addresses beyond the physical depth read as zero rather than indexing out of range.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                         rdata <= '0;
      else if ({1'b0, raddr} < DEPTH_A) rdata <= mem[raddr];
      else                              rdata <= '0;
   end

endmodule

// File: rtl/uart_cmd_parser.sv
// Assembles HDR/CMD/LEN/payload/CHK byte frames from the UART receiver into validated commands.
// Optional inter-byte timeout enabled by defining UART_CMD_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | hunting for the header byte
// CMD    | expecting the command code
// LEN    | expecting the payload length
// DATA   | storing payload bytes
// CHK    | expecting the checksum byte
// HOLD   | validated command presented, waiting for cmd_ack
module uart_cmd_parser
   import uart_cmd_pkg::*;
#(
   parameter int         MAX_LEN        = 16,
   parameter int         AW             = 4,
   parameter logic [7:0] HDR            = HDR_DEFAULT,
   parameter int         TIMEOUT_CYCLES = 21700
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [7:0]    rx_data,
   input  logic          rx_rdy,
   output logic          cmd_valid,
   input  logic          cmd_ack,
   output logic [7:0]    cmd_code,
   output logic [AW:0]   cmd_len,
   input  logic [AW-1:0] pl_raddr,
   output logic [7:0]    pl_rdata,
   output logic          chk_err,
   output logic          len_err,
   output logic          ovf_err,
   output logic          tmo_err,
   output logic          busy
);

   localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

   state_t           state, state_nxt;
   logic [7:0]       code_sh;
   logic [AW:0]      len_sh;
   logic [AW-1:0]    cnt, cnt_nxt;
   logic [CHK_W-1:0] chk, chk_nxt;
   logic             ld_code, ld_len, wr_en;
   logic             chk_e, len_e, ovf_e;
   logic             valid_set, valid_clr;
   logic             tmo_hit;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      ld_code   = 1'b0;
      ld_len    = 1'b0;
      wr_en     = 1'b0;
      chk_nxt   = chk;
      cnt_nxt   = cnt;
      chk_e     = 1'b0;
      len_e     = 1'b0;
      ovf_e     = 1'b0;
      valid_set = 1'b0;
      valid_clr = 1'b0;
      if (tmo_hit) begin
         state_nxt = S_IDLE;
      end else begin
         case (state)
            S_IDLE: if (rx_rdy && rx_data == HDR) state_nxt = S_CMD;
            S_CMD: if (rx_rdy) begin
               ld_code   = 1'b1;
               chk_nxt   = rx_data;
               state_nxt = S_LEN;
            end
            S_LEN: if (rx_rdy) begin
               if (rx_data > MAX_LEN_B) begin
                  len_e     = 1'b1;
                  state_nxt = S_IDLE;
               end else begin
                  ld_len    = 1'b1;
                  chk_nxt   = chk + rx_data;
                  cnt_nxt   = '0;
                  state_nxt = (rx_data == 8'd0) ? S_CHK : S_DATA;
               end
            end
            S_DATA: if (rx_rdy) begin
               wr_en   = 1'b1;
               chk_nxt = chk + rx_data;
               cnt_nxt = cnt + AW'(1);
               if ({1'b0, cnt} == len_sh - (AW+1)'(1)) state_nxt = S_CHK;
            end
            S_CHK: if (rx_rdy) begin
               if (rx_data == chk) begin
                  valid_set = 1'b1;
                  state_nxt = S_HOLD;
               end else begin
                  chk_e     = 1'b1;
                  state_nxt = S_IDLE;
               end
            end
            S_HOLD: begin
               // A byte arriving together with the ack is treated as the first byte of the next frame.
               if (cmd_ack) begin
                  valid_clr = 1'b1;
                  state_nxt = (rx_rdy && rx_data == HDR) ? S_CMD : S_IDLE;
               end else if (rx_rdy) begin
                  ovf_e = 1'b1;
               end
            end
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         code_sh   <= '0;
         len_sh    <= '0;
         cnt       <= '0;
         chk       <= '0;
         cmd_valid <= 1'b0;
         cmd_code  <= '0;
         cmd_len   <= '0;
         chk_err   <= 1'b0;
         len_err   <= 1'b0;
         ovf_err   <= 1'b0;
      end else begin
         if (ld_code) code_sh <= rx_data;
         if (ld_len)  len_sh  <= rx_data[AW:0];
         cnt     <= cnt_nxt;
         chk     <= chk_nxt;
         chk_err <= chk_e;
         len_err <= len_e;
         ovf_err <= ovf_e;
         if (valid_set) begin
            cmd_valid <= 1'b1;
            cmd_code  <= code_sh;
            cmd_len   <= len_sh;
         end else if (valid_clr) begin
            cmd_valid <= 1'b0;
         end
      end
   end

`ifdef UART_CMD_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [TMO_W-1:0] tmo_cnt;
   logic             tmo_active;

   assign tmo_active = (state == S_CMD) || (state == S_LEN) || (state == S_DATA) || (state == S_CHK);
   assign tmo_hit    = tmo_active && !rx_rdy && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tmo_cnt <= '0;
         tmo_err <= 1'b0;
      end else begin
         tmo_err <= tmo_hit;
         if (!tmo_active || rx_rdy || tmo_hit) tmo_cnt <= '0;
         else                                  tmo_cnt <= tmo_cnt + TMO_W'(1);
      end
   end
`else
   assign tmo_hit = 1'b0;
   assign tmo_err = 1'b0;
`endif

   assign busy = (state != S_IDLE);

   uart_cmd_buf #(
      .DEPTH (MAX_LEN),
      .AW    (AW)
   ) u_buf (
      .clk   (clk),
      .rst   (rst),
      .we    (wr_en),
      .waddr (cnt),
      .wdata (rx_data),
      .raddr (pl_raddr),
      .rdata (pl_rdata)
   );

endmodule
